// File: rtl/adc_channel_sequencer.sv
// -----------------------------------------------------------------------------
// adc_channel_sequencer
//
// Sequences one VCO-ADC channel datapath: holds it in reset, flushes it for one
// frame, issues SETTLE_SAMPLES settling strobes, then captures every datapath
// output produced by a RUN strobe, with a valid pulse and saturation stats.
//
// Ports
//   CLK_24M            in   sole clock, rising edge
//   reset              in   synchronous active-low reset
//   run                in   level request to start/keep sampling
//   channel_output     in   datapath two's-complement output (N_BITS)
//   clip_clear         in   pulse, clears clip_flag / clip_count
//   enable_sampling_3M out  one-cycle sampling strobe, period DIV
//   datapath_reset     out  active-low reset to the datapath
//   sample_out         out  captured sample, held between captures
//   sample_valid       out  one-cycle pulse when sample_out updates
//   busy               out  high outside IDLE
//   clip_flag          out  sticky full-scale indicator
//   clip_count         out  saturating count of full-scale captures
// -----------------------------------------------------------------------------
module adc_channel_sequencer #(
   parameter int DIV            = 8,
   parameter int SETTLE_SAMPLES = 4,
   parameter int N_BITS         = 9
) (
   input  logic              CLK_24M,
   input  logic              reset,
   input  logic              run,
   input  logic [N_BITS-1:0] channel_output,
   input  logic              clip_clear,
   output logic              enable_sampling_3M,
   output logic              datapath_reset,
   output logic [N_BITS-1:0] sample_out,
   output logic              sample_valid,
   output logic              busy,
   output logic              clip_flag,
   output logic [15:0]       clip_count
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_SAMPLES - 1);
   localparam logic [N_BITS-1:0] POS_FULL = {1'b0, {(N_BITS-1){1'b1}}};
   localparam logic [N_BITS-1:0] NEG_FULL = {1'b1, {(N_BITS-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SETTLE, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [DIV_W-1:0]   r_div_cnt, w_div_nxt, w_div_wrap;
   logic [SET_W-1:0]   r_settle_cnt, w_settle_nxt;
   logic               w_strobe_now, w_strobe_nxt, w_dp_rst_nxt, w_busy_nxt;
   logic               w_div_last, w_clip_hit;

   logic               r_strobe, r_dp_rst_n, r_busy;
   logic               r_cap_pend, r_valid;
   logic [N_BITS-1:0]  r_sample;
   logic               r_clip_flag;
   logic [15:0]        r_clip_count;

   assign w_div_last   = (r_div_cnt == DIV_LAST);
   assign w_div_wrap   = w_div_last ? '0 : r_div_cnt + DIV_W'(1);
   assign w_strobe_now = ((r_state == S_SETTLE) || (r_state == S_RUN)) && (r_div_cnt == '0);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_div_nxt    = r_div_cnt;
      w_settle_nxt = r_settle_cnt;
      case (r_state)
         S_IDLE: begin
            w_div_nxt    = '0;
            w_settle_nxt = '0;
            if (run) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (!run) begin
               w_state_nxt = S_IDLE;
               w_div_nxt   = '0;
            end else if (w_div_last) begin
               w_state_nxt = S_SETTLE;
               w_div_nxt   = '0;
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end
         end
         S_SETTLE: begin
            w_div_nxt = w_div_wrap;
            if (w_strobe_now) begin
               w_settle_nxt = r_settle_cnt + SET_W'(1);
               // Cadence is untouched: RUN simply inherits the running div_cnt.
               if (r_settle_cnt == SET_LAST) w_state_nxt = S_RUN;
            end
            if (w_div_last && !run) begin
               w_state_nxt  = S_IDLE;
               w_settle_nxt = '0;
            end
         end
         S_RUN: begin
            w_div_nxt = w_div_wrap;
            if (w_div_last && !run) begin
               w_state_nxt  = S_IDLE;
               w_settle_nxt = '0;
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_div_nxt    = '0;
            w_settle_nxt = '0;
         end
      endcase

      // Outputs are registered from the next-state view so they line up
      // with the state they describe.
      w_dp_rst_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);
      w_strobe_nxt = w_dp_rst_nxt && (w_div_nxt == '0);
      w_busy_nxt   = (w_state_nxt != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK_24M) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_div_cnt    <= '0;
         r_settle_cnt <= '0;
         r_strobe     <= 1'b0;
         r_dp_rst_n   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_div_cnt    <= w_div_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_strobe     <= w_strobe_nxt;
         r_dp_rst_n   <= w_dp_rst_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // The datapath updates channel_output on the edge closing the strobe
   // cycle, so capture waits one further cycle. The pipeline is independent
   // of the FSM so an in-flight capture completes even after a stop.
   assign w_clip_hit = r_cap_pend &&
                       ((channel_output == POS_FULL) || (channel_output == NEG_FULL));

   always_ff @(posedge CLK_24M) begin
      if (!reset) begin
         r_cap_pend   <= 1'b0;
         r_valid      <= 1'b0;
         r_sample     <= '0;
         r_clip_flag  <= 1'b0;
         r_clip_count <= '0;
      end else begin
         r_cap_pend <= w_strobe_now && (r_state == S_RUN);
         r_valid    <= r_cap_pend;
         if (r_cap_pend) r_sample <= channel_output;

         // A clear coinciding with a clip capture leaves exactly that clip.
         if (clip_clear) begin
            r_clip_flag  <= w_clip_hit;
            r_clip_count <= w_clip_hit ? 16'd1 : 16'd0;
         end else if (w_clip_hit) begin
            r_clip_flag <= 1'b1;
            if (r_clip_count != 16'hFFFF) r_clip_count <= r_clip_count + 16'd1;
         end
      end
   end

   assign enable_sampling_3M = r_strobe;
   assign datapath_reset     = r_dp_rst_n;
   assign busy               = r_busy;
   assign sample_out         = r_sample;
   assign sample_valid       = r_valid;
   assign clip_flag          = r_clip_flag;
   assign clip_count         = r_clip_count;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_channel_sequencer
//
// Self-checking bench. A small datapath model answers each strobe with a new
// channel_output one cycle later; values answering RUN strobes are pushed to a
// scoreboard with their due cycle and popped when sample_valid appears. Strobe,
// datapath_reset and busy timing are checked against frame arithmetic, and a
// clip model follows the captured values.
// -----------------------------------------------------------------------------
module tb_adc_channel_sequencer;

   localparam int DIV    = 8;
   localparam int SETTLE = 4;
   localparam int N      = 9;
   localparam logic [N-1:0] POS_FULL = 9'h0FF;
   localparam logic [N-1:0] NEG_FULL = 9'h100;

   typedef struct {
      logic [N-1:0] val;
      int           due;
   } exp_t;

   logic          CLK_24M;
   logic          reset;
   logic          run;
   logic [N-1:0]  channel_output;
   logic          clip_clear;
   logic          enable_sampling_3M;
   logic          datapath_reset;
   logic [N-1:0]  sample_out;
   logic          sample_valid;
   logic          busy;
   logic          clip_flag;
   logic [15:0]   clip_count;

   adc_channel_sequencer #(.DIV(DIV), .SETTLE_SAMPLES(SETTLE), .N_BITS(N)) dut (
      .CLK_24M            (CLK_24M),
      .reset              (reset),
      .run                (run),
      .channel_output     (channel_output),
      .clip_clear         (clip_clear),
      .enable_sampling_3M (enable_sampling_3M),
      .datapath_reset     (datapath_reset),
      .sample_out         (sample_out),
      .sample_valid       (sample_valid),
      .busy               (busy),
      .clip_flag          (clip_flag),
      .clip_count         (clip_count)
   );

   initial CLK_24M = 1'b0;
   always #5 CLK_24M = ~CLK_24M;

   int            n_checks = 0;
   int            n_fails  = 0;
   exp_t          exp_q[$];
   logic [N-1:0]  stim_q[$];
   logic [N-1:0]  last_cap = '0;
   int            cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] to_n(input int v);
      return v[N-1:0];
   endfunction

   function automatic logic is_full(input logic [N-1:0] v);
      return (v == POS_FULL) || (v == NEG_FULL);
   endfunction

   // Datapath model, scoreboard pop and clip model, all on the falling edge.
   logic          drive_pend = 1'b0;
   logic          drive_run  = 1'b0;
   int            n_strobes  = 0;
   logic [15:0]   m_cnt      = '0;
   logic          m_flag     = 1'b0;
   logic          clr_prev   = 1'b0;

   always @(negedge CLK_24M) begin : monitor
      exp_t e;
      cyc++;
      if (!reset) begin
         exp_q.delete();
         drive_pend = 1'b0;
         n_strobes  = 0;
         last_cap   = '0;
         m_cnt      = '0;
         m_flag     = 1'b0;
         clr_prev   = 1'b0;
      end else begin
         if (clr_prev) begin
            m_cnt  = '0;
            m_flag = 1'b0;
         end
         if (sample_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'(sample_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("valid_cycle", 32'(cyc), 32'(e.due));
               check("sample", 32'(sample_out), 32'(e.val));
               last_cap = e.val;
               if (is_full(e.val)) begin
                  m_flag = 1'b1;
                  if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
               end
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            check("valid_missing", 32'(sample_valid), 32'd1);
            e = exp_q.pop_front();
         end
         check("clip_count", 32'(clip_count), 32'(m_cnt));
         check("clip_flag", 32'(clip_flag), 32'(m_flag));
         clr_prev = clip_clear;

         if (drive_pend) begin
            if (drive_run && stim_q.size() > 0) channel_output = stim_q.pop_front();
            else channel_output = to_n(int'($urandom_range(400)) - 200);
            if (drive_run) exp_q.push_back('{val: channel_output, due: cyc + 1});
            drive_pend = 1'b0;
         end
         if (!datapath_reset) n_strobes = 0;
         if (enable_sampling_3M) begin
            n_strobes++;
            drive_pend = 1'b1;
            drive_run  = (n_strobes > SETTLE);
         end
      end
   end

   // One run request from IDLE. Checks frame timing every cycle; run drops
   // during cycle stop_at, clip_clear is high during clr_at, reset is pulled
   // low during rst_at.
   task automatic session(input int stop_at, input int end_at, input int clr_at, input int rst_at);
      int   idle_from;
      logic exp_dp, exp_strobe, exp_busy;
      idle_from = (stop_at < DIV) ? stop_at + 1 : (stop_at / DIV + 1) * DIV;
      run = 1'b1;
      for (int rel = 0; rel <= end_at; rel++) begin
         @(posedge CLK_24M); #1;
         exp_busy   = (rel < idle_from);
         exp_dp     = (rel >= DIV) && (rel < idle_from);
         exp_strobe = exp_dp && (rel % DIV == 0);
         check("strobe", 32'(enable_sampling_3M), 32'(exp_strobe));
         check("datapath_reset", 32'(datapath_reset), 32'(exp_dp));
         check("busy", 32'(busy), 32'(exp_busy));
         if (!sample_valid) check("hold", 32'(sample_out), 32'(last_cap));
         run        = (rel < stop_at);
         clip_clear = (rel == clr_at);
         if (rel == rst_at) begin
            reset = 1'b0;
            run   = 1'b0;
         end
      end
      clip_clear = 1'b0;
      run        = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_strobe"}, 32'(enable_sampling_3M), 32'd0);
      check({tag, "_dp_reset"}, 32'(datapath_reset), 32'd0);
      check({tag, "_sample"}, 32'(sample_out), 32'd0);
      check({tag, "_valid"}, 32'(sample_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_clip_flag"}, 32'(clip_flag), 32'd0);
      check({tag, "_clip_count"}, 32'(clip_count), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      reset          = 1'b0;
      run            = 1'b0;
      clip_clear     = 1'b0;
      channel_output = '0;
      repeat (3) @(posedge CLK_24M);
      #1;
      check_all_zero("reset");
      reset = 1'b1;
      @(posedge CLK_24M); #1;
      check("idle_busy", 32'(busy), 32'd0);

      // Two captures, stop after the second.
      stim_q.push_back(to_n(37));
      stim_q.push_back(to_n(-12));
      session(52, 60, -1, -1);

      // Stop inside the first RUN frame: only the strobe at 40 is captured.
      stim_q.push_back(to_n(100));
      session(44, 52, -1, -1);

      // Abort during FLUSH, then a full restart.
      session(3, 8, -1, -1);
      stim_q.push_back(to_n(5));
      session(44, 50, -1, -1);

      // Saturation: +255, -256, +254, then -256 together with clip_clear.
      stim_q.push_back(POS_FULL);
      stim_q.push_back(NEG_FULL);
      stim_q.push_back(to_n(254));
      stim_q.push_back(NEG_FULL);
      session(66, 74, 65, -1);
      check("clip_after_clear_count", 32'(clip_count), 32'd1);
      check("clip_after_clear_flag", 32'(clip_flag), 32'd1);

      // A lone clear in IDLE empties the statistics.
      clip_clear = 1'b1;
      @(posedge CLK_24M); #1;
      clip_clear = 1'b0;
      check("clear_idle_count", 32'(clip_count), 32'd0);
      check("clear_idle_flag", 32'(clip_flag), 32'd0);

      // Reset one cycle after the RUN strobe at 40 cancels that capture.
      stim_q.push_back(POS_FULL);
      session(1000, 41, -1, 41);
      @(posedge CLK_24M); #1;
      check_all_zero("mid_reset");
      reset = 1'b1;
      stim_q.delete();
      repeat (4) @(posedge CLK_24M);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
